// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_queue
// Purpose  : Writeback FIFO draining into an 8x32 register array write port;
//            optional operand forwarding enabled by macro WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid_i,
    output logic                         wb_ready_o,
    input  logic [ADDR_W-1:0]            wb_addr_i,
    input  logic [DATA_W-1:0]            wb_data_i,
    input  logic                         rf_hold_i,
    output logic                         rf_we_o,
    output logic [ADDR_W-1:0]            rf_waddr_o,
    output logic [DATA_W-1:0]            rf_wdata_o,
    input  logic [ADDR_W-1:0]            rd_addr1_i,
    input  logic [ADDR_W-1:0]            rd_addr2_i,
    input  logic [DATA_W-1:0]            rf_rdata1_i,
    input  logic [DATA_W-1:0]            rf_rdata2_i,
    output logic [DATA_W-1:0]            op1_o,
    output logic [DATA_W-1:0]            op2_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              push, pop;

    // Flags come from the registered count only, so wb_ready never sees rf_hold.
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign wb_ready_o = !full_o;
    assign count_o    = count_q;
    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    always_comb begin
        push       = wb_valid_i && !full_o;
        pop        = !empty_o && !rf_hold_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rf_we_d    = pop;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rf_waddr_d = addr_mem_q[rd_ptr_q];
            rf_wdata_d = data_mem_q[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= wb_addr_i;
            data_mem_q[wr_ptr_q] <= wb_data_i;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to newest so the youngest match overrides; the write register ranks below the FIFO.
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] ra,
                                              input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] v;
        logic [PTR_W-1:0]  idx;
        v = rdata;
        if (rf_we_q && (rf_waddr_q == ra)) begin
            v = rf_wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem_q[idx] == ra)) begin
                v = data_mem_q[idx];
            end
        end
        return v;
    endfunction

    always_comb begin
        op1_o = fwd(rd_addr1_i, rf_rdata1_i);
        op2_o = fwd(rd_addr2_i, rf_rdata2_i);
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1_i, rd_addr2_i};
    assign op1_o = rf_rdata1_i;
    assign op2_o = rf_rdata2_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_queue
// Purpose  : Directed and randomized checks of regfile_wb_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          rf_hold = 1'b0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rd_addr1 = '0;
    logic [AW-1:0] rd_addr2 = '0;
    logic [DW-1:0] rf_rdata1 = '0;
    logic [DW-1:0] rf_rdata2 = '0;
    logic [DW-1:0] op1, op2;
    logic [2:0]    count;
    logic          empty, full;

    regfile_wb_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid_i (wb_valid),
        .wb_ready_o (wb_ready),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .rf_hold_i  (rf_hold),
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata),
        .rd_addr1_i (rd_addr1),
        .rd_addr2_i (rd_addr2),
        .rf_rdata1_i(rf_rdata1),
        .rf_rdata2_i(rf_rdata2),
        .op1_o      (op1),
        .op2_o      (op2),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending writebacks as a plain queue plus the last array write.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            bit acc;
            ent_t e;
            acc = wb_valid && (mq.size() < DEPTH);
            if (mq.size() > 0 && !rf_hold) begin
                e = mq.pop_front();
                m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
            end else begin
                m_we = 1'b0;
            end
            if (acc) mq.push_back('{a: wb_addr, d: wb_data});
        end
    end

    function automatic logic [DW-1:0] exp_op(input logic [AW-1:0] ra, input logic [DW-1:0] rdata);
`ifdef WB_BYPASS_EN
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == ra) return mq[i].d;
        if (m_we && m_waddr == ra) return m_wdata;
`endif
        return rdata;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("count",    {29'd0, count},    DW'(mq.size()));
            check("empty",    {31'd0, empty},    DW'(mq.size() == 0));
            check("full",     {31'd0, full},     DW'(mq.size() == DEPTH));
            check("wb_ready", {31'd0, wb_ready}, DW'(mq.size() != DEPTH));
            check("rf_we",    {31'd0, rf_we},    {31'd0, m_we});
            check("rf_waddr", {29'd0, rf_waddr}, {29'd0, m_waddr});
            check("rf_wdata", rf_wdata, m_wdata);
            check("op1", op1, exp_op(rd_addr1, rf_rdata1));
            check("op2", op2, exp_op(rd_addr2, rf_rdata2));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        wb_valid = 1'b0;
        rf_hold  = 1'b0;
        for (int i = 0; i < 20 && !(empty && !rf_we); i++) cyc();
        check("drain_done", {31'd0, empty && !rf_we}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit accepted;

        // Reset and idle
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("idle_we",    {31'd0, rf_we},    32'd0);
            check("idle_count", {29'd0, count},    32'd0);
            check("idle_empty", {31'd0, empty},    32'd1);
            check("idle_ready", {31'd0, wb_ready}, 32'd1);
        end

        // Two back-to-back pushes drain on consecutive cycles
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 32'hACEDCAFE;
        cyc();
        check("b2b_no_cut_through", {31'd0, rf_we}, 32'd0);
        wb_addr = 3'd3; wb_data = 32'hDEADBEEF;
        cyc();
        wb_valid = 1'b0;
        check("b2b_we0",    {31'd0, rf_we},    32'd1);
        check("b2b_addr0",  {29'd0, rf_waddr}, 32'd0);
        check("b2b_data0",  rf_wdata,          32'hACEDCAFE);
        cyc();
        check("b2b_we1",    {31'd0, rf_we},    32'd1);
        check("b2b_addr1",  {29'd0, rf_waddr}, 32'd3);
        check("b2b_data1",  rf_wdata,          32'hDEADBEEF);
        cyc();
        check("b2b_we_end", {31'd0, rf_we},    32'd0);

        // Hold with five pushes of r7; the fifth waits for space
        rf_hold = 1'b1; wb_valid = 1'b1; wb_addr = 3'd7;
        for (int k = 1; k <= 4; k++) begin
            wb_data = DW'(k);
            cyc();
        end
        check("hold_count", {29'd0, count},    32'd4);
        check("hold_full",  {31'd0, full},     32'd1);
        check("hold_ready", {31'd0, wb_ready}, 32'd0);
        wb_data = 32'd5;
        rf_hold = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 2) wb_valid = 1'b0;
            check("hold_we",   {31'd0, rf_we},    32'd1);
            check("hold_addr", {29'd0, rf_waddr}, 32'd7);
            check("hold_data", rf_wdata,          DW'(k));
        end
        cyc();
        check("hold_we_end", {31'd0, rf_we}, 32'd0);
        check("hold_empty",  {31'd0, empty}, 32'd1);

        // Forwarding of the youngest pending value
        rf_hold = 1'b1; wb_valid = 1'b1; wb_addr = 3'd2;
        rd_addr1 = 3'd2; rf_rdata1 = 32'h0;
        wb_data = 32'h11; cyc();
        wb_data = 32'h22; cyc();
        wb_valid = 1'b0;
`ifdef WB_BYPASS_EN
        check("bypass_op1", op1, 32'h22);
`else
        check("bypass_op1", op1, 32'h0);
`endif
        drain();

        // Full queue, continuous producer, pointer wrap, then reset mid-stream
        rf_hold = 1'b1; wb_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wb_addr = AW'($urandom); wb_data = $urandom;
            cyc();
        end
        check("stream_full", {31'd0, full}, 32'd1);
        rf_hold = 1'b0;
        for (int k = 0; k < 12; k++) begin
            accepted = wb_valid && wb_ready;
            cyc();
            check("stream_we", {31'd0, rf_we}, 32'd1);
            if (accepted) begin
                wb_addr = AW'($urandom); wb_data = $urandom;
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0; wb_valid = 1'b0;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_we",    {31'd0, rf_we}, 32'd0);
        cyc();
        check("rst_no_stale_we", {31'd0, rf_we}, 32'd0);
        check("rst_empty",       {31'd0, empty}, 32'd1);

        // Randomized traffic with a compliant producer and occasional reset
        for (int n = 0; n < 3000; n++) begin
            accepted = wb_valid && wb_ready;
            if (!wb_valid || accepted) begin
                wb_valid = ($urandom_range(0, 99) < 60);
                wb_addr  = AW'($urandom);
                wb_data  = $urandom;
            end
            rf_hold   = ($urandom_range(0, 99) < 35);
            rd_addr1  = AW'($urandom);
            rd_addr2  = AW'($urandom);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            rst       = ($urandom_range(0, 299) == 0);
            if (rst) wb_valid = 1'b0;
            cyc();
            rst = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
